// File: rtl/mem_arbiter_if.sv
// Request/grant and RAM-side bundle for mem_arbiter.
// The arbiter takes the master modport; cores and RAM model take the slave modport.
interface mem_arbiter_if #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
);
    logic [CPUS-1:0]             iREN;
    logic [CPUS-1:0]             dREN;
    logic [CPUS-1:0]             dWEN;
    logic [CPUS-1:0][WORD_W-1:0] iaddr;
    logic [CPUS-1:0][WORD_W-1:0] daddr;
    logic [CPUS-1:0][WORD_W-1:0] dstore;
    logic [CPUS-1:0]             iwait;
    logic [CPUS-1:0]             dwait;
    logic [CPUS-1:0][WORD_W-1:0] iload;
    logic [CPUS-1:0][WORD_W-1:0] dload;
    logic                        ramREN;
    logic                        ramWEN;
    logic [WORD_W-1:0]           ramaddr;
    logic [WORD_W-1:0]           ramstore;
    logic [WORD_W-1:0]           ramload;
    logic [1:0]                  ramstate;
    logic                        ram_err;

    modport master (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

    modport slave (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port among 2*CPUS instruction/data requesters.
// Latency: one ARB cycle then GRANT; wait drops combinationally on the first ACCESS cycle.
// Backpressure: every wait stays high until the granted port's ACCESS cycle; BUSY/FREE/ERROR hold the grant.
module mem_arbiter #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.master bus
);
    localparam int N  = 2 * CPUS;
    localparam int IW = $clog2(N);
    localparam int KW = (CPUS > 1) ? $clog2(CPUS) : 1;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic {ARB, GRANT} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     gidx, gidx_nxt;
    logic [IW-1:0]     rr, rr_nxt;
    logic [IW-1:0]     pick, scan, gnext;
    logic [N-1:0]      req;
    logic [KW-1:0]     gk;
    logic              gdata, greq, any_req, err_set, err_q;
    logic              ren, wen;
    logic [CPUS-1:0]   iwait_c, dwait_c;

    // Even index = data port k, odd index = instruction port k.
    always_comb begin
        req = '0;
        for (int k = 0; k < CPUS; k++) begin
            req[2*k]   = bus.dREN[k] | bus.dWEN[k];
            req[2*k+1] = bus.iREN[k];
        end
    end

    // First requester at or after rr, wrapping at N.
    always_comb begin
        pick    = rr;
        any_req = 1'b0;
        scan    = rr;
        for (int i = 0; i < N; i++) begin
            if (!any_req && req[scan]) begin
                pick    = scan;
                any_req = 1'b1;
            end
            scan = (scan == IW'(N - 1)) ? '0 : scan + 1'b1;
        end
    end

    assign gk    = KW'(gidx >> 1);
    assign gdata = ~gidx[0];
    assign greq  = gdata ? (bus.dREN[gk] | bus.dWEN[gk]) : bus.iREN[gk];
    assign gnext = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        rr_nxt    = rr;
        err_set   = 1'b0;
        ren       = 1'b0;
        wen       = 1'b0;
        iwait_c   = '1;
        dwait_c   = '1;
        case (state)
            ARB: begin
                if (any_req) begin
                    gidx_nxt  = pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                wen = gdata & bus.dWEN[gk];
                ren = gdata ? (bus.dREN[gk] & ~bus.dWEN[gk]) : bus.iREN[gk];
                if (!greq) begin
                    // Requester withdrew: leave quietly, still hand priority on.
                    state_nxt = ARB;
                    rr_nxt    = gnext;
                end else if (bus.ramstate == RS_ACCESS) begin
                    state_nxt = ARB;
                    rr_nxt    = gnext;
                    if (gdata) dwait_c[gk] = 1'b0;
                    else       iwait_c[gk] = 1'b0;
                end else if (bus.ramstate == RS_ERROR) begin
                    err_set = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ARB;
            gidx  <= '0;
            rr    <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            gidx  <= gidx_nxt;
            rr    <= rr_nxt;
            err_q <= err_q | err_set;
        end
    end

    assign bus.ramREN   = ren;
    assign bus.ramWEN   = wen;
    assign bus.ramaddr  = gdata ? bus.daddr[gk] : bus.iaddr[gk];
    assign bus.ramstore = bus.dstore[gk];
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    assign bus.iload    = {CPUS{bus.ramload}};
    assign bus.dload    = {CPUS{bus.ramload}};
    assign bus.ram_err  = err_q;
endmodule
